// File: rtl/t05_sram_responder.sv
// Responder for the team_05 SRAM bus: fixed-latency byte-enabled word array at BASE_ADDR.
// Optional SRAM_RESP_CLEAR_EN zeroes the array after every reset before accepting requests.
module t05_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        r_en,
    input  logic [3:0]  select,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic [31:0] data_o,
    output logic        err_o
);
    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        CLEAR = 2'd2
    } state_t;

`ifdef SRAM_RESP_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    localparam logic   RST_BUSY  = 1'b1;
    logic [AW-1:0] clr_idx;
`else
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             accept, commit;

    logic             req_wr;
    logic             req_oow;
    logic [AW-1:0]    req_word;
    logic [31:0]      req_data;
    logic [3:0]       req_sel;

    logic [31:0]      off, word_full;
    logic             in_oow;

    logic [31:0]      mem [DEPTH_WORDS];

    // Window decode; the subtraction wraps for addr < BASE_ADDR, hence the explicit compare.
    assign off       = addr - BASE_ADDR;
    assign word_full = off >> 2;
    assign in_oow    = (addr < BASE_ADDR) || (word_full >= 32'(DEPTH_WORDS));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and request handshake decode
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_en || r_en) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(LATENCY - 1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
`ifdef SRAM_RESP_CLEAR_EN
            CLEAR: begin
                if (clr_idx == AW'(DEPTH_WORDS - 1)) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o <= RST_BUSY;
            err_o  <= 1'b0;
            data_o <= '0;
        end else begin
            busy_o <= (state_d != IDLE);
            err_o  <= commit && req_oow;
            if (commit && !req_wr) data_o <= req_oow ? 32'h0 : mem[req_word];
        end
    end

    // Request capture; both enables high is a write
    always_ff @(posedge clk) begin
        if (rst) begin
            req_wr   <= 1'b0;
            req_oow  <= 1'b0;
            req_word <= '0;
            req_data <= '0;
            req_sel  <= '0;
        end else if (accept) begin
            req_wr   <= wr_en;
            req_oow  <= in_oow;
            req_word <= word_full[AW-1:0];
            req_data <= data_i;
            req_sel  <= select;
        end
    end

`ifdef SRAM_RESP_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst)                 clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
    end
`endif

    // Array storage: contents survive rst, only committed writes touch it
    always_ff @(posedge clk) begin
`ifdef SRAM_RESP_CLEAR_EN
        if (!rst && state == CLEAR) begin
            mem[clr_idx] <= 32'h0;
        end else
`endif
        if (!rst && commit && req_wr && !req_oow) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) mem[req_word][8*b +: 8] <= req_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_t05_sram_responder.sv
// Directed bench for t05_sram_responder: transaction-level reference model plus literal spot checks.
module tb_t05_sram_responder;
    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        r_en = 1'b0;
    logic [3:0]  select = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic        busy_o;
    logic [31:0] data_o;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;

    t05_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .r_en(r_en), .select(select),
        .addr(addr), .data_i(data_i), .busy_o(busy_o), .data_o(data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted at cycle c completes at cycle c+LAT.
    logic [31:0] mmem [int];
    bit          m_busy = 0, m_err = 0, m_known = 1, started = 0, pending = 0;
    logic [31:0] m_data = 32'h0;
    int          cyc = 0, commit_at = 0;
    bit          p_wr, p_oow;
    int          p_word;
    logic [31:0] p_data;
    logic [3:0]  p_sel;

    function automatic bit out_of_window(input logic [31:0] a);
        return (a < BASE) || (((a - BASE) / 4) >= 32'(DEPTH));
    endfunction

    always @(posedge clk) begin
        logic [31:0] mask, old;
        cyc++;
        started = 1;
        m_err = 0;
        if (rst) begin
            m_busy = 0; m_data = 32'h0; m_known = 1; pending = 0;
        end else if (pending) begin
            if (cyc == commit_at) begin
                pending = 0;
                m_busy  = 0;
                m_err   = p_oow;
                if (p_wr) begin
                    if (!p_oow) begin
                        mask = {{8{p_sel[3]}}, {8{p_sel[2]}}, {8{p_sel[1]}}, {8{p_sel[0]}}};
                        old  = mmem.exists(p_word) ? mmem[p_word] : 32'h0;
                        mmem[p_word] = (old & ~mask) | (p_data & mask);
                    end
                end else if (p_oow) begin
                    m_data = 32'h0; m_known = 1;
                end else if (mmem.exists(p_word)) begin
                    m_data = mmem[p_word]; m_known = 1;
                end else begin
                    m_known = 0;
                end
            end
        end else if (wr_en || r_en) begin
            pending   = 1;
            commit_at = cyc + LAT;
            m_busy    = 1;
            p_wr      = wr_en;
            p_oow     = out_of_window(addr);
            p_word    = int'((addr - BASE) / 4);
            p_data    = data_i;
            p_sel     = select;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy_o", {31'h0, busy_o}, {31'h0, m_busy});
            chk("err_o", {31'h0, err_o}, {31'h0, m_err});
            if (m_known) chk("data_o", data_o, m_data);
        end
    end

    task automatic wait_fall(output int n);
        n = 0;
        while (busy_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (busy_o) chk("busy_timeout", {31'h0, busy_o}, 32'h0);
    endtask

    task automatic req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        int n;
        wr_en = w; r_en = r; addr = a; data_i = d; select = s;
        @(posedge clk);
        @(negedge clk);
        wr_en = 0; r_en = 0;
        wait_fall(n);
        chk("busy_len", 32'(n), 32'(LAT));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] t3v [3];
        int n;
        t3v[0] = 32'h0A0B_0C0D; t3v[1] = 32'h1357_9BDF; t3v[2] = 32'h8642_0ECA;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        rst = 0;
        @(negedge clk);

        // Full-word write and read-back
        req(1, 0, 32'h3300_0010, 32'hCAFE_F00D, 4'hF);
        req(0, 1, 32'h3300_0010, 32'h0, 4'h0);
        chk("t1_read", data_o, 32'hCAFE_F00D);

        // Byte-enable merge
        req(1, 0, 32'h3300_0100, 32'h1122_3344, 4'hF);
        req(1, 0, 32'h3300_0100, 32'hAABB_CCDD, 4'b0101);
        req(0, 1, 32'h3300_0103, 32'h0, 4'h0);
        chk("t2_merge", data_o, 32'h11BB_33DD);

        // Preload words used later
        for (int i = 0; i < 3; i++) req(1, 0, BASE + 32'h200 + 32'(4 * i), t3v[i], 4'hF);
        req(1, 0, 32'h3300_0000, 32'h0123_4567, 4'hF);
        req(1, 0, 32'h3300_0020, 32'h55AA_55AA, 4'hF);
        req(1, 1, 32'h3300_0030, 32'h7777_0000, 4'hC);
        req(0, 1, 32'h3300_0030, 32'h0, 4'h0);
        chk("both_en_is_write", data_o, 32'h7777_0000);

        // Back-to-back reads with r_en held high
        r_en = 1; addr = BASE + 32'h200;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t3_busy_rise", {31'h0, busy_o}, 32'h1);
            addr = BASE + 32'h200 + 32'(4 * ((i < 2) ? i + 1 : i));
            wait_fall(n);
            chk("t3_busy_len", 32'(n), 32'(LAT));
            chk("t3_data", data_o, t3v[i]);
            if (i == 2) r_en = 0;
        end

        // Out-of-window accesses
        req(0, 1, 32'h0, 32'h0, 4'h0);
        chk("t4_rd_err", {31'h0, err_o}, 32'h1);
        chk("t4_rd_zero", data_o, 32'h0);
        req(1, 0, 32'h3300_4000, 32'hDEAD_BEEF, 4'hF);
        chk("t4_wr_err", {31'h0, err_o}, 32'h1);
        req(0, 1, 32'h32FF_FFFC, 32'h0, 4'h0);
        chk("below_base_err", {31'h0, err_o}, 32'h1);
        req(0, 1, 32'h3300_0000, 32'h0, 4'h0);
        chk("t4_alias_intact", data_o, 32'h0123_4567);
        chk("t4_no_err", {31'h0, err_o}, 32'h0);
        req(0, 1, 32'h3300_3FFC, 32'h0, 4'h0);
        chk("last_word_in_window", {31'h0, err_o}, 32'h0);

        // Reset during the second busy cycle of a write
        wr_en = 1; addr = 32'h3300_0020; data_i = 32'h9999_9999; select = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wr_en = 0;
        chk("t5_busy1", {31'h0, busy_o}, 32'h1);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_busy_rst", {31'h0, busy_o}, 32'h0);
        chk("t5_data_rst", data_o, 32'h0);
        rst = 0;
        @(negedge clk);
        req(0, 1, 32'h3300_0020, 32'h0, 4'h0);
        chk("t5_old_value", data_o, 32'h55AA_55AA);
        req(0, 1, 32'h3300_0010, 32'h0, 4'h0);
        chk("kept_over_rst", data_o, 32'hCAFE_F00D);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
